// File: rtl/tmds_decoder.sv
// TMDS channel receiver: finds the 10-bit word boundary from control tokens and decodes VD/CD/VDE.
// Optional running-disparity checker is compiled in with `define TMDS_DECODER_DISP_CHECK_EN.
module tmds_decoder #(
  parameter int LOCK_COUNT = 8,
  parameter int TIMEOUT    = 8191,
  parameter int DISP_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] raw,
  output logic [7:0] VD,
  output logic [1:0] CD,
  output logic       VDE,
  output logic       locked,
  output logic [3:0] offset,
  output logic       disp_err,
  output logic [1:0] dbg_state_o
);

  // Encoding is visible on dbg_state_o: 0 = HUNT, 1 = VERIFY, 2 = LOCKED.
  typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0]  LockCnt = 4'(LOCK_COUNT);
  localparam logic [12:0] TmoMax  = 13'(TIMEOUT);

  // Returns {is_token, cd}.
  function automatic logic [2:0] tok_lookup(input logic [9:0] w);
    case (w)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  prev_q;
  logic [3:0]  offset_q, offset_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [12:0] tmo_q, tmo_d, tmo_inc;
  logic [3:0]  alt_off_q, alt_off_d;
  logic [3:0]  alt_cnt_q, alt_cnt_d, alt_next;
  logic [9:0]  s1_word_q;
  logic        s1_tok_q, s1_lock_q;
  logic [1:0]  s1_cd_q;
  logic [7:0]  vd_q, vd_d;
  logic [1:0]  cd_q, cd_d;
  logic        vde_q, vde_d, locked_q;

  // cand(9) reaches only raw[8]; raw[9] enters through prev_q.
  logic [18:0] win;
  logic [9:0]  match_vec, cur_word;
  logic [2:0]  cur_look, look;
  logic        hunt_hit, alt_hit;
  logic [3:0]  hunt_k, alt_k;

  assign win = {raw[8:0], prev_q};

  always_comb begin
    match_vec = '0;
    cur_word  = '0;
    look      = '0;
    for (int k = 0; k < 10; k++) begin
      look         = tok_lookup(win[k +: 10]);
      match_vec[k] = look[2];
      if (offset_q == 4'(k)) cur_word = win[k +: 10];
    end
    cur_look = tok_lookup(cur_word);
    hunt_hit = 1'b0;
    hunt_k   = '0;
    alt_hit  = 1'b0;
    alt_k    = '0;
    // Descending scan so the lowest matching offset wins.
    for (int k = 9; k >= 0; k--) begin
      if (match_vec[k]) begin
        hunt_hit = 1'b1;
        hunt_k   = 4'(k);
        if (offset_q != 4'(k)) begin
          alt_hit = 1'b1;
          alt_k   = 4'(k);
        end
      end
    end
  end

  assign tmo_inc  = (tmo_q >= TmoMax) ? TmoMax : tmo_q + 13'd1;
  assign alt_next = (alt_cnt_q != 4'd0 && alt_k == alt_off_q) ? alt_cnt_q + 4'd1 : 4'd1;

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    alt_off_d = alt_off_q;
    alt_cnt_d = alt_cnt_q;
    case (state_q)
      HUNT: begin
        tmo_d     = '0;
        alt_cnt_d = '0;
        if (hunt_hit) begin
          offset_d = hunt_k;
          cnt_d    = 4'd1;
          state_d  = VERIFY;
        end
      end
      VERIFY: begin
        if (cur_look[2]) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == LockCnt) begin
            state_d   = LOCKED;
            cnt_d     = '0;
            tmo_d     = '0;
            alt_cnt_d = '0;
          end
        end else begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      end
      LOCKED: begin
        if (cur_look[2]) begin
          tmo_d = '0;
        end else if (tmo_inc == TmoMax) begin
          state_d = HUNT;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_inc;
        end
        // A persistent token stream at another offset moves the boundary without dropping lock.
        if (alt_hit) begin
          alt_off_d = alt_k;
          alt_cnt_d = alt_next;
          if (alt_next == LockCnt) begin
            offset_d  = alt_k;
            tmo_d     = '0;
            alt_cnt_d = '0;
            state_d   = LOCKED;
          end
        end else begin
          alt_cnt_d = '0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  logic [7:0] t, vd_dec;
  always_comb begin
    t         = s1_word_q[9] ? ~s1_word_q[7:0] : s1_word_q[7:0];
    vd_dec    = '0;
    vd_dec[0] = t[0];
    for (int i = 1; i < 8; i++) vd_dec[i] = t[i] ^ t[i-1] ^ ~s1_word_q[8];
    vd_d  = (s1_lock_q && !s1_tok_q) ? vd_dec : 8'd0;
    cd_d  = (s1_lock_q && s1_tok_q) ? s1_cd_q : 2'd0;
    vde_d = s1_lock_q && !s1_tok_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      prev_q    <= '0;
      offset_q  <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      alt_off_q <= '0;
      alt_cnt_q <= '0;
      s1_word_q <= '0;
      s1_tok_q  <= 1'b0;
      s1_cd_q   <= '0;
      s1_lock_q <= 1'b0;
      vd_q      <= '0;
      cd_q      <= '0;
      vde_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= raw;
      offset_q  <= offset_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      alt_off_q <= alt_off_d;
      alt_cnt_q <= alt_cnt_d;
      s1_word_q <= cur_word;
      s1_tok_q  <= cur_look[2];
      s1_cd_q   <= cur_look[1:0];
      s1_lock_q <= (state_d == LOCKED);
      vd_q      <= vd_d;
      cd_q      <= cd_d;
      vde_q     <= vde_d;
      locked_q  <= s1_lock_q;
    end
  end

`ifdef TMDS_DECODER_DISP_CHECK_EN
  logic [5:0] acc_q, acc_d;
  logic       derr_q, derr_d;
  logic [3:0] ones;
  logic [6:0] w7, sum7, mag7;

  // Two's-complement arithmetic on 7 bits; acc stays within +/-DISP_LIMIT.
  always_comb begin
    ones = '0;
    for (int i = 0; i < 10; i++) ones = ones + {3'd0, s1_word_q[i]};
    w7     = {3'd0, ones} - 7'd5;
    sum7   = {acc_q[5], acc_q} + w7;
    mag7   = sum7[6] ? (~sum7 + 7'd1) : sum7;
    acc_d  = sum7[5:0];
    derr_d = 1'b0;
    if (!s1_lock_q || s1_tok_q) begin
      acc_d = '0;
    end else if (mag7 > 7'(DISP_LIMIT)) begin
      acc_d  = '0;
      derr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      derr_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      derr_q <= derr_d;
    end
  end

  assign disp_err = derr_q;
`else
  // No checker built; the limit is only meaningful with it, so this is constant 0.
  assign disp_err = (DISP_LIMIT < 0);
`endif

  assign VD          = vd_q;
  assign CD          = cd_q;
  assign VDE         = vde_q;
  assign locked      = locked_q;
  assign offset      = offset_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/tmds_decoder.md
Name: tmds_decoder

Overview:
- Receive-side counterpart of the TMDS encoder. Takes unaligned 10-bit words from the serial-to-parallel deserializer, one per clk.
- Finds the 10-bit word boundary using the four control tokens and holds lock.
- Decodes each aligned word back to 8-bit video data (VD), 2-bit control data (CD) and the data-enable flag (VDE).
- One instance per channel (red, green, blue); sits between the deserializer and the video timing recovery logic.

Parameters:
- LOCK_COUNT, 8, consecutive control tokens at one bit offset needed to declare lock.
- TIMEOUT, 8191, cycles with no control token at the locked offset before lock is dropped.
- DISP_LIMIT, 8, running-disparity magnitude bound; only used when the optional feature is compiled in.

Ports:
- clk  in  1  word clock, one raw word per cycle.
- rst_n  in  1  asynchronous active-low reset.
- raw  in  10  deserialized word; bit 0 arrived first, alignment unknown.
- VD  out  8  decoded video data.
- CD  out  2  decoded control data.
- VDE  out  1  1 = data word, 0 = control token.
- locked  out  1  word alignment established.
- offset  out  4  current bit offset, 0..9.
- disp_err  out  1  one-cycle disparity-error pulse.

Behaviour:
- Reset: clk and rst_n as already decided (one clock, asynchronous active-low reset). Asserting rst_n low at any time, including mid-lock, immediately clears:
  - VD=0, CD=0, VDE=0, locked=0, offset=0, disp_err=0;
  - state=HUNT, all counters 0, previous word register 0.
- Window: prev <= raw every cycle. win[19:0] = {raw, prev}. cand(k) = win[k+9:k] for k=0..9.
- Tokens: 1101010100 -> CD=00; 0010101011 -> CD=01; 0101010100 -> CD=10; 1010101011 -> CD=11. All other words are data.
- Data decode of aligned word d:
  - t = d[9] ? ~d[7:0] : d[7:0];
  - VD[0] = t[0];
  - for i=1..7: VD[i] = t[i] ^ t[i-1] ^ ~d[8].
- Pipeline:
  - stage 1 registers cand(offset) and its token-match result;
  - stage 2 registers VD/CD/VDE.
  - Latency: raw sampled at edge n appears on the outputs after edge n+2.
- HUNT:
  - Each cycle, compare all 10 candidates against the four tokens.
  - On a match, the lowest matching k is loaded into offset, cnt=1, go to VERIFY.
- VERIFY:
  - cand(offset) is a token: cnt++; when cnt reaches LOCK_COUNT, go to LOCKED and assert locked.
  - cand(offset) is not a token: go to HUNT, cnt=0. If a token matches at another offset in that same cycle, HUNT still handles it on the next cycle; no same-cycle re-seed.
- LOCKED:
  - Token at offset: reset tmo=0.
  - Otherwise tmo++. When tmo reaches TIMEOUT, go to HUNT: locked=0, tmo=0.
  - A token at a different offset for LOCK_COUNT consecutive cycles (own counter, cleared whenever that does not hold) re-aligns in place: offset updated, locked stays 1, tmo=0.
- While locked=0: outputs held at VD=0, CD=0, VDE=0; offset still updates.
- The locked output is registered and aligned with the stage-2 outputs, so the first locked output word is a valid decode.
- Counter widths: cnt 4 bits; tmo 13 bits, saturating guard at TIMEOUT.

Optional Feature:
- Macro: TMDS_DECODER_DISP_CHECK_EN.
- When defined, for each aligned word in LOCKED:
  - w = popcount(d) - 5, signed, range -5..+5;
  - acc, 6-bit signed, acc <= acc + w;
  - acc is cleared to 0 on every control token.
  - If |acc+w| > DISP_LIMIT: disp_err pulses for 1 cycle, aligned with that word's stage-2 output, and acc is cleared to 0.
- When not defined: disp_err is tied 0 and no accumulator exists.

Test Plan:
- Reset: assert rst_n low mid-stream during LOCKED -> all outputs 0 and locked=0 within the same cycle, asynchronously; after release, state is HUNT.
- Alignment: feed a stream of 0010101011 tokens pre-rotated by 3 bits for 8 words, then data -> offset=3, locked=1 after the 8th token + 2 cycles, CD=01, VDE=0.
- Data decode: after lock, send encoder outputs for VD=8'h00, 8'hFF, 8'h55, 8'hA5 -> VD matches each value with VDE=1, 2 cycles later, in order.
- Failed verify: 5 tokens at offset 6, then 1 data word, then 8 tokens at offset 2 -> never locked on 6; ends locked=1, offset=2.
- Timeout: lock, then send 8191 data words with no token -> locked falls to 0 on the word that takes tmo to 8191; VDE forced 0.
- Disparity (macro defined): lock, then 3 data words of 1111111100 (w=+3 each) -> disp_err pulses once on the 3rd word (acc 9 > 8); no pulse without the macro.
